// File: rtl/alu_z_stage.sv
// rtl/alu_z_stage.sv - ALU result-capture stage holding Z pair and HI/LO registers
//
// Waits SETTLE_CYCLES edges after an accepted capture request so that deep
// combinational ALU paths (MUL/DIV) settle, then registers the result and
// its status flags. A combinational bus port drives the Z registers out.
//
// Ports:
//   clk          system clock, rising edge
//   clear        synchronous active-high reset
//   result_lo    ALU low result
//   result_hi    ALU high result (MUL high word / DIV remainder)
//   op_wide      current op is MUL/DIV, sampled when zin is accepted
//   zin          capture request pulse
//   zlo_out      drive z_lo onto the bus
//   zhi_out      drive z_hi onto the bus
//   busy         settle in progress
//   z_valid      Z holds a completed capture
//   z_lo, z_hi   Z register pair
//   hi_q, lo_q   architectural HI/LO registers
//   zero_flag    captured result is zero
//   neg_flag     captured result is negative
//   bus_data     bus drive value
//   bus_drive    bus driven this cycle
//   bus_conflict zlo_out and zhi_out asserted together
//   overrun      sticky, zin arrived while busy
module alu_z_stage #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] result_lo,
    input  logic [WIDTH-1:0] result_hi,
    input  logic             op_wide,
    input  logic             zin,
    input  logic             zlo_out,
    input  logic             zhi_out,
    output logic             busy,
    output logic             z_valid,
    output logic [WIDTH-1:0] z_lo,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] hi_q,
    output logic [WIDTH-1:0] lo_q,
    output logic             zero_flag,
    output logic             neg_flag,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_drive,
    output logic             bus_conflict,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam logic [3:0] COUNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [3:0]       count_q, count_d;
    logic             wide_q, wide_d;
    logic [WIDTH-1:0] z_lo_q, z_lo_d;
    logic [WIDTH-1:0] z_hi_q, z_hi_d;
    logic [WIDTH-1:0] hi_r_q, hi_r_d;
    logic [WIDTH-1:0] lo_r_q, lo_r_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             overrun_q, overrun_d;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wide_d    = wide_q;
        z_lo_d    = z_lo_q;
        z_hi_d    = z_hi_q;
        hi_r_d    = hi_r_q;
        lo_r_d    = lo_r_q;
        zero_d    = zero_q;
        neg_d     = neg_q;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE, S_VALID: begin
                if (zin) begin
                    state_d = S_WAIT;
                    count_d = COUNT_LOAD;
                    wide_d  = op_wide;
                end
            end
            S_WAIT: begin
                if (zin) begin
                    // Restart the settle window; the earlier request is dropped.
                    count_d   = COUNT_LOAD;
                    wide_d    = op_wide;
                    overrun_d = 1'b1;
                end else if (count_q != 4'd0) begin
                    count_d = count_q - 4'd1;
                end else begin
                    z_lo_d = result_lo;
                    z_hi_d = wide_q ? result_hi : '0;
                    if (wide_q) begin
                        lo_r_d = result_lo;
                        hi_r_d = result_hi;
                    end
                    zero_d  = (result_lo == '0) && (!wide_q || (result_hi == '0));
                    neg_d   = wide_q ? result_hi[WIDTH-1] : result_lo[WIDTH-1];
                    state_d = S_VALID;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= S_IDLE;
            count_q   <= 4'd0;
            wide_q    <= 1'b0;
            z_lo_q    <= '0;
            z_hi_q    <= '0;
            hi_r_q    <= '0;
            lo_r_q    <= '0;
            zero_q    <= 1'b0;
            neg_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wide_q    <= wide_d;
            z_lo_q    <= z_lo_d;
            z_hi_q    <= z_hi_d;
            hi_r_q    <= hi_r_d;
            lo_r_q    <= lo_r_d;
            zero_q    <= zero_d;
            neg_q     <= neg_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy      = (state_q == S_WAIT);
    assign z_valid   = (state_q == S_VALID);
    assign z_lo      = z_lo_q;
    assign z_hi      = z_hi_q;
    assign hi_q      = hi_r_q;
    assign lo_q      = lo_r_q;
    assign zero_flag = zero_q;
    assign neg_flag  = neg_q;
    assign overrun   = overrun_q;

    // Bus reflects the registers as they stand now, so a capture edge shows
    // up on the bus only in the following cycle. z_lo has priority.
    assign bus_drive    = zlo_out | zhi_out;
    assign bus_conflict = zlo_out & zhi_out;
    assign bus_data     = zlo_out ? z_lo_q : (zhi_out ? z_hi_q : '0);

endmodule

// File: tb/tb_alu_z_stage.sv
// tb/tb_alu_z_stage.sv - directed self-checking bench for alu_z_stage
module tb_alu_z_stage;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clear;
    logic [W-1:0] result_lo, result_hi;
    logic         op_wide, zin, zlo_out, zhi_out;
    logic         busy, z_valid, zero_flag, neg_flag;
    logic         bus_drive, bus_conflict, overrun;
    logic [W-1:0] z_lo, z_hi, hi_q, lo_q, bus_data;

    int n_vec = 0;
    int n_err = 0;

    alu_z_stage #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .clear(clear),
        .result_lo(result_lo), .result_hi(result_hi),
        .op_wide(op_wide), .zin(zin),
        .zlo_out(zlo_out), .zhi_out(zhi_out),
        .busy(busy), .z_valid(z_valid),
        .z_lo(z_lo), .z_hi(z_hi), .hi_q(hi_q), .lo_q(lo_q),
        .zero_flag(zero_flag), .neg_flag(neg_flag),
        .bus_data(bus_data), .bus_drive(bus_drive),
        .bus_conflict(bus_conflict), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        clear = 1'b1; result_lo = '0; result_hi = '0;
        op_wide = 1'b0; zin = 1'b0; zlo_out = 1'b0; zhi_out = 1'b0;
        tick(); tick();
        clear = 1'b0;
        tick();

        // reset / idle
        chk("rst_busy", W'(busy), 0);
        chk("rst_valid", W'(z_valid), 0);
        chk("rst_zlo", z_lo, 0);
        chk("rst_zhi", z_hi, 0);
        chk("rst_hi", hi_q, 0);
        chk("rst_lo", lo_q, 0);
        chk("rst_flags", W'({zero_flag, neg_flag, overrun}), 0);
        chk("rst_bus", bus_data, 0);
        chk("rst_drive", W'({bus_drive, bus_conflict}), 0);

        // narrow op
        result_lo = 32'h0000_0005; result_hi = 32'hDEAD_BEEF; op_wide = 1'b0; zin = 1'b1;
        tick(); zin = 1'b0;
        chk("nar_busy1", W'(busy), 1);
        tick();
        chk("nar_busy2", W'(busy), 1);
        chk("nar_valid_early", W'(z_valid), 0);
        chk("nar_zlo_hold", z_lo, 0);
        tick();
        chk("nar_busy_done", W'(busy), 0);
        chk("nar_valid", W'(z_valid), 1);
        chk("nar_zlo", z_lo, 32'h5);
        chk("nar_zhi", z_hi, 0);
        chk("nar_hi", hi_q, 0);
        chk("nar_lo", lo_q, 0);
        chk("nar_zero", W'(zero_flag), 0);
        chk("nar_neg", W'(neg_flag), 0);
        zlo_out = 1'b1; #1;
        chk("nar_bus", bus_data, 32'h5);
        chk("nar_drive", W'(bus_drive), 1);
        chk("nar_noconf", W'(bus_conflict), 0);
        zlo_out = 1'b0; #1;
        chk("nar_bus_off", bus_data, 0);

        // wide op, issued back-to-back from VALID
        result_lo = 32'h0; result_hi = 32'hFFFF_FFFF; op_wide = 1'b1; zin = 1'b1;
        tick(); zin = 1'b0; op_wide = 1'b0;
        tick(); tick();
        chk("wid_valid", W'(z_valid), 1);
        chk("wid_zlo", z_lo, 0);
        chk("wid_zhi", z_hi, 32'hFFFF_FFFF);
        chk("wid_hi", hi_q, 32'hFFFF_FFFF);
        chk("wid_lo", lo_q, 0);
        chk("wid_neg", W'(neg_flag), 1);
        chk("wid_zero", W'(zero_flag), 0);
        chk("wid_no_overrun", W'(overrun), 0);

        // restart during WAIT; ALU changes mid-wait are ignored
        result_lo = 32'h20; zin = 1'b1;
        tick();
        result_lo = 32'h10;
        tick(); zin = 1'b0;
        chk("rs_overrun", W'(overrun), 1);
        chk("rs_busy", W'(busy), 1);
        result_lo = 32'h99;
        tick();
        chk("rs_busy2", W'(busy), 1);
        chk("rs_zlo_hold", z_lo, 0);
        result_lo = 32'h10;
        tick();
        chk("rs_valid", W'(z_valid), 1);
        chk("rs_zlo", z_lo, 32'h10);
        chk("rs_zhi", z_hi, 0);
        chk("rs_hi_keep", hi_q, 32'hFFFF_FFFF);
        chk("rs_neg", W'(neg_flag), 0);

        // narrow zero ignores result_hi
        result_lo = 32'h0; result_hi = 32'h5; zin = 1'b1;
        tick(); zin = 1'b0;
        tick(); tick();
        chk("z_zero", W'(zero_flag), 1);
        chk("z_overrun_sticky", W'(overrun), 1);

        // reset mid-WAIT abandons capture
        clear = 1'b1; tick(); clear = 1'b0;
        chk("cl_overrun", W'(overrun), 0);
        result_lo = 32'h77; zin = 1'b1;
        tick(); zin = 1'b0; clear = 1'b1;
        tick(); clear = 1'b0;
        tick(); tick(); tick();
        chk("cl_busy", W'(busy), 0);
        chk("cl_valid", W'(z_valid), 0);
        chk("cl_zlo", z_lo, 0);

        // bus conflict
        result_lo = 32'hA; result_hi = 32'hB; op_wide = 1'b1; zin = 1'b1;
        tick(); zin = 1'b0; op_wide = 1'b0;
        tick(); tick();
        zlo_out = 1'b1; zhi_out = 1'b1; #1;
        chk("bc_data", bus_data, 32'hA);
        chk("bc_conf", W'(bus_conflict), 1);
        chk("bc_drive", W'(bus_drive), 1);
        zlo_out = 1'b0; #1;
        chk("bc_hi_data", bus_data, 32'hB);
        zhi_out = 1'b0;

        // bus during capture edge shows old value, new one after
        result_lo = 32'hC; zin = 1'b1;
        tick(); zin = 1'b0;
        tick();
        zlo_out = 1'b1; #1;
        chk("ce_old", bus_data, 32'hA);
        tick();
        chk("ce_new", bus_data, 32'hC);
        zlo_out = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
